pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/TRAP control, redirect priority, epc and instret.
// Define MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic        jump,
    input  logic        jalr,
    input  logic        trapRet,
    input  logic [31:0] immExt,
    input  logic [31:0] aluResult,
    output logic [31:0] PC,
    output logic [31:0] pcPlus4,
    output logic        pcValid,
    output logic        flush,
    output logic        trap,
    output logic [31:0] epc,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    logic        redirect;
    logic        trap_hit;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign pcPlus4 = PC + 32'd4;
    assign pcValid = (state == RUN);

    always_comb begin
        redirect = trapRet | jalr | jump | branchTaken;
        if (trapRet)
            target = epc;
        else if (jalr)
            target = aluResult & ~32'd1;
        else if (jump | branchTaken)
            target = PC + immExt;
        else
            target = pcPlus4;
`ifdef MISALIGN_TRAP_EN
        trap_hit = redirect && (target[1:0] != 2'b00);
        next_pc  = target;
`else
        // Without the trap, low target bits are simply dropped.
        trap_hit = 1'b0;
        next_pc  = redirect ? (target & ~32'd3) : target;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            PC      <= RESET_VECTOR;
            epc     <= 32'd0;
            instret <= 32'd0;
            flush   <= 1'b0;
            trap    <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    PC    <= RESET_VECTOR;
                    flush <= 1'b0;
                    trap  <= 1'b0;
                end
                RUN: begin
                    if (stall) begin
                        flush <= 1'b0;
                        trap  <= 1'b0;
                    end else if (trap_hit) begin
                        state <= TRAP;
                        epc   <= PC;
                        PC    <= TRAP_VECTOR;
                        flush <= 1'b1;
                        trap  <= 1'b1;
                    end else begin
                        PC      <= next_pc;
                        instret <= instret + 32'd1;
                        flush   <= redirect;
                        trap    <= 1'b0;
                    end
                end
                TRAP: begin
                    state <= RUN;
                    PC    <= TRAP_VECTOR;
                    flush <= 1'b0;
                    trap  <= 1'b0;
                end
                default: begin
                    state <= BOOT;
                    PC    <= RESET_VECTOR;
                    flush <= 1'b0;
                    trap  <= 1'b0;
                end
            endcase
        end
    end

endmodule
